i2c_slave_regbank: RTL and testbench
====================================

// Module: i2c_slave_regbank
// PURPOSE
// Parametrised I2C target with an integrated register bank: NUM_RW host-writable control registers and NUM_RO
// read-only status registers, each REG_W bits wide. Bit-level protocol, pointer handling, auto-increment and
// atomic multi-byte access are all in one block. It replaces the fixed two-module slave/register pair at the
// board-control level; the pad-level open-drain buffer sits outside the block.
// PARAMETERS
// I2C_ADDR    7'h41  7-bit target address
// NUM_RW      9      number of RW registers, indices 0..NUM_RW-1
// NUM_RO      4      number of RO registers, indices NUM_RW..NUM_RW+NUM_RO-1; NUM_RW+NUM_RO <= 256
// REG_W       16     register width; 8, 16, 24 or 32; B = REG_W/8 bytes per register
// RW_RST_VAL  0      reset value of every RW register (REG_W bits)
// SYNC_STAGES 2      synchroniser depth on scl_i and sda_i, >= 2
// PORTS
// clk        in   1             system clock, >= 20x SCL frequency
// rstn       in   1             synchronous, active-low reset
// scl_i      in   1             SCL pad input (asynchronous)
// sda_i      in   1             SDA pad input (asynchronous)
// sda_oe     out  1             1 = pull SDA low (open-drain enable)
// ro_data    in   NUM_RO*REG_W  RO register values; register k occupies [k*REG_W +: REG_W]
// rw_data    out  NUM_RW*REG_W  RW register contents, same packing
// rw_wr_stb  out  NUM_RW        1-cycle pulse on the cycle RW register k is committed
// busy       out  1             high from an address match until STOP or reset
// BEHAVIOUR
// - Reset (rstn=0 at a clk edge): FSM=IDLE, sda_oe=0, busy=0, rw_wr_stb=0, rw_data=RW_RST_VAL for all registers,
//   pointer=0, byte counter=0. A reset mid-transfer releases SDA on the next edge; the bus is ignored until a new START.
// - Sync: both inputs pass SYNC_STAGES flops. START = SDA falling while SCL high; STOP = SDA rising while SCL high.
//   SDA is sampled on synchronised SCL rise; sda_oe changes only on the cycle after synchronised SCL fall.
//   No clock stretching is performed.
// - FSM states: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WR, WR_ACK, RD, RD_ACK, IGNORE.
//   START from any state -> ADDR (repeated start included). STOP from any state -> IDLE, busy=0.
// - ADDR: shift 8 bits, MSB first. Match on [7:1]==I2C_ADDR -> ADDR_ACK (ACK, busy=1); else -> IGNORE (sda_oe=0).
//   After ACK: R/W=0 -> PTR; R/W=1 -> RD, using the current pointer.
// - PTR: a byte < NUM_RW+NUM_RO is ACKed, loads the pointer and clears the byte counter. Otherwise it is NACKed
//   with the pointer unchanged, then -> IGNORE. After a valid PTR the FSM continues in WR.
// - WR: bytes are MSB first into a REG_W holding register; every byte is ACKed. On the ACK of byte B:
//   - if pointer < NUM_RW: rw_data[pointer] <= holding and rw_wr_stb[pointer]=1 for exactly that cycle;
//   - RO index: data is discarded, no strobe.
//   Then pointer increments. A STOP or START before byte B discards the partial word; rw_data and strobes are unchanged.
// - RD: on loading byte 0 of a register, the whole register (RW or RO) is snapshotted into a shadow, so multi-byte
//   reads are atomic. Bytes are sent MSB first. Master ACK -> next byte; ACK after byte B -> pointer increments and
//   the next register is snapshotted. Master NACK -> IGNORE until STOP/START, pointer stays incremented only if
//   the full register was read.
// - Pointer wrap: after index NUM_RW+NUM_RO-1, the pointer wraps to 0 in both read and write.
// - Simultaneous events: START/STOP detection has priority over bit sampling in the same cycle.
//   At most one rw_wr_stb bit is high in any cycle.
// TESTING
// 1 Write 0x82,0x03,0x12,0x34,0x56,0x78,STOP -> all bytes ACKed; reg3=0x1234, reg4=0x5678; stb[3] then stb[4], 1 cycle each.
// 2 reg9 ro=0xBEEF; write 0x82,0x09, Sr, 0x83, read 2 bytes (ACK, NACK); change ro to 0x1111 after byte 0 -> bytes 0xBE,0xEF.
// 3 Pointer 0x0C, read 4 bytes -> ro reg12 MSB, LSB, then rw reg0 MSB, LSB (wrap to 0).
// 4 Address byte 0xA0 -> NACK, sda_oe never 1, no strobes; pointer byte 0x0D -> NACK, the next write is ignored.
// 5 Partial write 0x82,0x02,0xAA,STOP -> reg2 unchanged, no strobe; a repeated START after 0xAA behaves the same.
// 6 rstn=0 for one cycle while the target drives a read 0 -> sda_oe=0 next edge, rw_data=0, busy=0, bus ignored until START.

Source files
------------

// File: rtl/i2c_slave_regbank.sv
// i2c_slave_regbank: I2C target with NUM_RW host-writable control registers and
// NUM_RO read-only status registers. It handles the pointer byte, auto-increment
// with wrap, atomic multi-byte writes (holding register) and reads (shadow).
module i2c_slave_regbank #(
  parameter logic [6:0]       I2C_ADDR    = 7'h41,
  parameter int               NUM_RW      = 9,
  parameter int               NUM_RO      = 4,
  parameter int               REG_W       = 16,
  parameter logic [REG_W-1:0] RW_RST_VAL  = '0,
  parameter int               SYNC_STAGES = 2
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    scl_i,
  input  logic                    sda_i,
  output logic                    sda_oe,
  input  logic [NUM_RO*REG_W-1:0] ro_data,
  output logic [NUM_RW*REG_W-1:0] rw_data,
  output logic [NUM_RW-1:0]       rw_wr_stb,
  output logic                    busy
);
  localparam int NREG = NUM_RW + NUM_RO;
  localparam int B    = REG_W / 8;

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WR, WR_ACK, RD, RD_ACK, IGNORE
  } state_t;

  logic [SYNC_STAGES-1:0] r_scl_sync, r_sda_sync;
  logic                   r_scl_d, r_sda_d;
  logic                   w_scl, w_sda, w_scl_rise, w_scl_fall, w_start, w_stop;

  state_t                 r_state, w_state;
  logic [3:0]             r_bit, w_bit;
  logic [7:0]             r_shift, w_shift;
  logic [7:0]             r_ptr, w_ptr, w_ptr_inc;
  logic [2:0]             r_bcnt, w_bcnt;
  logic [REG_W-1:0]       r_hold, w_hold, w_hold_nx;
  logic [REG_W-1:0]       r_tx, w_tx, w_tx_sh;
  logic                   r_oe, w_oe, r_busy, w_busy, r_mack, w_mack, r_rnw, w_rnw;
  logic [NUM_RW*REG_W-1:0] r_rw, w_rw;
  logic [NUM_RW-1:0]      r_stb, w_stb;
  logic [REG_W-1:0]       w_cur_word, w_nxt_word;
  logic                   w_byte_last;

  // Pad synchronisers plus one cycle of history for edge / START / STOP detection.
  // Left unreset so a mid-transfer reset cannot fabricate a bus edge.
  always_ff @(posedge clk) begin
    r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], scl_i};
    r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], sda_i};
    r_scl_d    <= w_scl;
    r_sda_d    <= w_sda;
  end

  assign w_scl      = r_scl_sync[SYNC_STAGES-1];
  assign w_sda      = r_sda_sync[SYNC_STAGES-1];
  assign w_scl_rise = w_scl & ~r_scl_d;
  assign w_scl_fall = ~w_scl & r_scl_d;
  assign w_start    = w_scl & r_scl_d & r_sda_d & ~w_sda;
  assign w_stop     = w_scl & r_scl_d & ~r_sda_d & w_sda;

  assign w_ptr_inc   = (r_ptr == 8'(NREG - 1)) ? 8'd0 : r_ptr + 8'd1;
  assign w_hold_nx   = (r_hold << 8) | REG_W'(r_shift);
  assign w_tx_sh     = r_tx << 1;
  assign w_byte_last = (r_bcnt == 3'(B - 1));

  // Register read mux at the current pointer and at the pointer after increment
  always_comb begin
    w_cur_word = '0;
    w_nxt_word = '0;
    for (int k = 0; k < NUM_RW; k++) begin
      if (r_ptr == 8'(k))     w_cur_word = r_rw[k*REG_W +: REG_W];
      if (w_ptr_inc == 8'(k)) w_nxt_word = r_rw[k*REG_W +: REG_W];
    end
    for (int k = 0; k < NUM_RO; k++) begin
      if (r_ptr == 8'(NUM_RW + k))     w_cur_word = ro_data[k*REG_W +: REG_W];
      if (w_ptr_inc == 8'(NUM_RW + k)) w_nxt_word = ro_data[k*REG_W +: REG_W];
    end
  end

  // Next-state and datapath logic; bus conditions override bit handling
  always_comb begin
    w_state = r_state;
    w_bit   = r_bit;
    w_shift = r_shift;
    w_ptr   = r_ptr;
    w_bcnt  = r_bcnt;
    w_hold  = r_hold;
    w_tx    = r_tx;
    w_oe    = r_oe;
    w_busy  = r_busy;
    w_mack  = r_mack;
    w_rnw   = r_rnw;
    w_rw    = r_rw;
    w_stb   = '0;
    if (w_start) begin
      w_state = ADDR;
      w_bit   = '0;
      w_bcnt  = '0;
      w_oe    = 1'b0;
    end else if (w_stop) begin
      w_state = IDLE;
      w_bit   = '0;
      w_bcnt  = '0;
      w_oe    = 1'b0;
      w_busy  = 1'b0;
    end else begin
      case (r_state)
        ADDR, PTR, WR: begin
          if (w_scl_rise) begin
            w_shift = {r_shift[6:0], w_sda};
            w_bit   = r_bit + 4'd1;
          end else if (w_scl_fall && r_bit == 4'd8) begin
            w_bit = '0;
            case (r_state)
              ADDR: begin
                if (r_shift[7:1] == I2C_ADDR) begin
                  w_state = ADDR_ACK;
                  w_oe    = 1'b1;
                  w_busy  = 1'b1;
                  w_rnw   = r_shift[0];
                end else begin
                  w_state = IGNORE;
                end
              end
              PTR: begin
                if ({1'b0, r_shift} < 9'(NREG)) begin
                  w_state = PTR_ACK;
                  w_oe    = 1'b1;
                  w_ptr   = r_shift;
                  w_bcnt  = '0;
                end else begin
                  w_state = IGNORE;
                end
              end
              default: begin
                w_state = WR_ACK;
                w_oe    = 1'b1;
                w_hold  = w_hold_nx;
                if (w_byte_last) begin
                  // RO targets swallow the word silently
                  for (int k = 0; k < NUM_RW; k++) begin
                    if (r_ptr == 8'(k)) begin
                      w_rw[k*REG_W +: REG_W] = w_hold_nx;
                      w_stb[k]               = 1'b1;
                    end
                  end
                  w_ptr  = w_ptr_inc;
                  w_bcnt = '0;
                end else begin
                  w_bcnt = r_bcnt + 3'd1;
                end
              end
            endcase
          end
        end
        ADDR_ACK, PTR_ACK, WR_ACK: begin
          if (w_scl_fall) begin
            w_bit = '0;
            w_oe  = 1'b0;
            if (r_state == ADDR_ACK && r_rnw) begin
              w_state = RD;
              w_tx    = w_cur_word;
              w_oe    = ~w_cur_word[REG_W-1];
            end else if (r_state == ADDR_ACK) begin
              w_state = PTR;
            end else begin
              w_state = WR;
            end
          end
        end
        RD: begin
          if (w_scl_rise) begin
            w_bit = r_bit + 4'd1;
          end else if (w_scl_fall) begin
            if (r_bit == 4'd8) begin
              w_state = RD_ACK;
              w_bit   = '0;
              w_oe    = 1'b0;
            end else begin
              w_tx = w_tx_sh;
              w_oe = ~w_tx_sh[REG_W-1];
            end
          end
        end
        RD_ACK: begin
          if (w_scl_rise) begin
            w_mack = w_sda;
          end else if (w_scl_fall) begin
            if (w_byte_last) begin
              w_ptr  = w_ptr_inc;
              w_bcnt = '0;
            end else begin
              w_bcnt = r_bcnt + 3'd1;
            end
            if (!r_mack) begin
              w_state = RD;
              if (w_byte_last) begin
                w_tx = w_nxt_word;
                w_oe = ~w_nxt_word[REG_W-1];
              end else begin
                w_tx = w_tx_sh;
                w_oe = ~w_tx_sh[REG_W-1];
              end
            end else begin
              w_state = IGNORE;
              w_bcnt  = '0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // State and register bank update with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state <= IDLE;
      r_bit   <= '0;
      r_shift <= '0;
      r_ptr   <= '0;
      r_bcnt  <= '0;
      r_hold  <= '0;
      r_tx    <= '0;
      r_oe    <= 1'b0;
      r_busy  <= 1'b0;
      r_mack  <= 1'b0;
      r_rnw   <= 1'b0;
      r_rw    <= {NUM_RW{RW_RST_VAL}};
      r_stb   <= '0;
    end else begin
      r_state <= w_state;
      r_bit   <= w_bit;
      r_shift <= w_shift;
      r_ptr   <= w_ptr;
      r_bcnt  <= w_bcnt;
      r_hold  <= w_hold;
      r_tx    <= w_tx;
      r_oe    <= w_oe;
      r_busy  <= w_busy;
      r_mack  <= w_mack;
      r_rnw   <= w_rnw;
      r_rw    <= w_rw;
      r_stb   <= w_stb;
    end
  end

  assign sda_oe    = r_oe;
  assign busy      = r_busy;
  assign rw_data   = r_rw;
  assign rw_wr_stb = r_stb;

endmodule

// File: tb/tb_i2c_slave_regbank.sv
// Directed bench for i2c_slave_regbank: a bit-banged I2C master drives the bus,
// a vector table covers register write/readback, hand sequences cover corners.
`timescale 1ns/1ps
module tb_i2c_slave_regbank;
  localparam int NUM_RW = 9;
  localparam int NUM_RO = 4;
  localparam int REG_W  = 16;
  localparam int Q      = 60;  // quarter SCL period in ns; clk is 10 ns

  logic                    clk = 1'b0, rstn = 1'b0, scl_m = 1'b1, sda_m = 1'b1;
  logic                    scl_i, sda_i, sda_oe, busy;
  logic [NUM_RO*REG_W-1:0] ro_data;
  logic [NUM_RW*REG_W-1:0] rw_data;
  logic [NUM_RW-1:0]       rw_wr_stb;

  int n_vec = 0, n_err = 0;
  int stb_log[$];
  int stb_cycles = 0, stb_multi = 0, oe_cycles = 0;

  assign scl_i = scl_m;
  assign sda_i = sda_m & ~sda_oe;

  always #5 clk = ~clk;

  i2c_slave_regbank dut (
    .clk(clk), .rstn(rstn), .scl_i(scl_i), .sda_i(sda_i), .sda_oe(sda_oe),
    .ro_data(ro_data), .rw_data(rw_data), .rw_wr_stb(rw_wr_stb), .busy(busy)
  );

  // Record every strobe and every cycle the target pulls SDA
  always @(negedge clk) begin
    if (rw_wr_stb != '0) begin
      stb_cycles++;
      if ($countones(rw_wr_stb) > 1) stb_multi++;
      for (int k = 0; k < NUM_RW; k++) if (rw_wr_stb[k]) stb_log.push_back(k);
    end
    if (sda_oe) oe_cycles++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] rwr(input int k);
    return rw_data[k*REG_W +: REG_W];
  endfunction

  function automatic int stb_at(input int i);
    return (stb_log.size() > i) ? stb_log[i] : -1;
  endfunction

  task automatic i2c_start();
    sda_m = 1'b1; #Q; scl_m = 1'b1; #Q; sda_m = 1'b0; #Q; scl_m = 1'b0; #Q;
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; #Q; scl_m = 1'b1; #Q; sda_m = 1'b1; #Q;
  endtask

  task automatic wbit(input logic b);
    sda_m = b; #Q; scl_m = 1'b1; #Q; #Q; scl_m = 1'b0; #Q;
  endtask

  task automatic rbit(output logic b);
    sda_m = 1'b1; #Q; scl_m = 1'b1; #Q; b = sda_i; #Q; scl_m = 1'b0; #Q;
  endtask

  task automatic wbyte(input logic [7:0] d, output logic ack);
    logic b;
    for (int i = 7; i >= 0; i--) wbit(d[i]);
    rbit(b);
    ack = ~b;
  endtask

  task automatic rbyte(output logic [7:0] d, input logic ack);
    logic b;
    for (int i = 7; i >= 0; i--) begin rbit(b); d[i] = b; end
    wbit(~ack);
  endtask

  task automatic wr_reg(input logic [7:0] ptr, input logic [15:0] w, output logic all_ack);
    logic a;
    all_ack = 1'b1;
    i2c_start();
    wbyte(8'h82, a);     all_ack &= a;
    wbyte(ptr, a);       all_ack &= a;
    wbyte(w[15:8], a);   all_ack &= a;
    wbyte(w[7:0], a);    all_ack &= a;
    i2c_stop();
  endtask

  task automatic rd_reg(input logic [7:0] ptr, output logic [15:0] w, output logic all_ack);
    logic a;
    all_ack = 1'b1;
    i2c_start();
    wbyte(8'h82, a);     all_ack &= a;
    wbyte(ptr, a);       all_ack &= a;
    i2c_start();
    wbyte(8'h83, a);     all_ack &= a;
    rbyte(w[15:8], 1'b1);
    rbyte(w[7:0], 1'b0);
    i2c_stop();
  endtask

  typedef struct {
    logic [7:0]  ptr;
    logic [15:0] wdata;
    logic [15:0] exp_rd;
    int          exp_stb;  // -1: no strobe expected
  } vec_t;

  initial begin
    vec_t        vt[5];
    logic        a, acks;
    logic [7:0]  d0, d1, d2, d3;
    logic [15:0] w;

    vt[0] = '{8'd1,  16'hCAFE, 16'hCAFE, 1};
    vt[1] = '{8'd8,  16'h0102, 16'h0102, 8};
    vt[2] = '{8'd10, 16'hFFFF, 16'h2222, -1};
    vt[3] = '{8'd5,  16'h8001, 16'h8001, 5};
    vt[4] = '{8'd12, 16'h5A5A, 16'hC0DE, -1};

    ro_data = {16'hC0DE, 16'h3333, 16'h2222, 16'hBEEF};

    // reset state
    repeat (10) @(negedge clk);
    chk("rst sda_oe", 32'(sda_oe), 0);
    chk("rst busy", 32'(busy), 0);
    chk("rst stb", 32'(rw_wr_stb), 0);
    chk("rst rw_data", 32'(rw_data != '0), 0);
    rstn = 1'b1;
    #Q;

    // two-register burst write
    stb_log.delete(); stb_cycles = 0; acks = 1'b1;
    i2c_start();
    wbyte(8'h82, a); acks &= a;
    chk("burst busy", 32'(busy), 1);
    wbyte(8'h03, a); acks &= a;
    wbyte(8'h12, a); acks &= a;
    wbyte(8'h34, a); acks &= a;
    wbyte(8'h56, a); acks &= a;
    wbyte(8'h78, a); acks &= a;
    i2c_stop(); #Q;
    chk("burst acks", 32'(acks), 1);
    chk("burst reg3", 32'(rwr(3)), 32'h1234);
    chk("burst reg4", 32'(rwr(4)), 32'h5678);
    chk("burst stb n", 32'(stb_log.size()), 2);
    chk("burst stb0", 32'(stb_at(0)), 3);
    chk("burst stb1", 32'(stb_at(1)), 4);
    chk("burst stb cycles", 32'(stb_cycles), 2);
    chk("burst busy after stop", 32'(busy), 0);

    // vector table: write then read back each register
    for (int i = 0; i < 5; i++) begin
      stb_log.delete();
      wr_reg(vt[i].ptr, vt[i].wdata, acks);
      chk($sformatf("vec%0d wr acks", i), 32'(acks), 1);
      chk($sformatf("vec%0d stb n", i), 32'(stb_log.size()), (vt[i].exp_stb < 0) ? 0 : 1);
      if (vt[i].exp_stb >= 0) begin
        chk($sformatf("vec%0d stb idx", i), 32'(stb_at(0)), 32'(vt[i].exp_stb));
        chk($sformatf("vec%0d rw_data", i), 32'(rwr(vt[i].exp_stb)), 32'(vt[i].exp_rd));
      end
      rd_reg(vt[i].ptr, w, acks);
      chk($sformatf("vec%0d rd acks", i), 32'(acks), 1);
      chk($sformatf("vec%0d rd word", i), 32'(w), 32'(vt[i].exp_rd));
    end

    // atomic read of RO reg9 while its input changes mid-read
    i2c_start();
    wbyte(8'h82, a); wbyte(8'h09, a);
    i2c_start();
    wbyte(8'h83, a);
    rbyte(d0, 1'b1);
    ro_data[15:0] = 16'h1111;
    rbyte(d1, 1'b0);
    i2c_stop();
    chk("atomic b0", 32'(d0), 32'hBE);
    chk("atomic b1", 32'(d1), 32'hEF);
    // full register read then NACK: pointer moved on to reg10
    i2c_start();
    wbyte(8'h83, a);
    rbyte(d0, 1'b1); rbyte(d1, 1'b0);
    i2c_stop();
    chk("ptr after nack", 32'({d0, d1}), 32'h2222);

    // read across the wrap from reg12 to reg0
    wr_reg(8'd0, 16'hA55A, acks);
    i2c_start();
    wbyte(8'h82, a); wbyte(8'h0C, a);
    i2c_start();
    wbyte(8'h83, a);
    rbyte(d0, 1'b1); rbyte(d1, 1'b1); rbyte(d2, 1'b1); rbyte(d3, 1'b0);
    i2c_stop();
    chk("wrap read", {d0, d1, d2, d3}, 32'hC0DEA55A);

    // foreign address and out-of-range pointer
    oe_cycles = 0; stb_log.delete();
    i2c_start();
    wbyte(8'hA0, a); chk("bad addr ack", 32'(a), 0);
    wbyte(8'h55, a); chk("bad addr data ack", 32'(a), 0);
    i2c_stop();
    chk("bad addr oe", 32'(oe_cycles), 0);
    chk("bad addr busy", 32'(busy), 0);
    i2c_start();
    wbyte(8'h82, a); chk("badptr addr ack", 32'(a), 1);
    wbyte(8'h0D, a); chk("badptr ack", 32'(a), 0);
    wbyte(8'h11, a); chk("badptr data ack", 32'(a), 0);
    wbyte(8'h22, a);
    i2c_stop();
    chk("badptr stb", 32'(stb_log.size()), 0);
    chk("badptr reg0", 32'(rwr(0)), 32'hA55A);
    i2c_start();
    wbyte(8'h83, a);
    rbyte(d0, 1'b1); rbyte(d1, 1'b0);
    i2c_stop();
    chk("badptr ptr kept", 32'({d0, d1}), 32'hCAFE);

    // partial writes terminated by STOP and by repeated START
    stb_log.delete();
    i2c_start();
    wbyte(8'h82, a); wbyte(8'h02, a); wbyte(8'hAA, a);
    i2c_stop();
    chk("partial stop reg2", 32'(rwr(2)), 0);
    i2c_start();
    wbyte(8'h82, a); wbyte(8'h02, a); wbyte(8'hAA, a);
    i2c_start();
    wbyte(8'hA0, a);
    i2c_stop();
    chk("partial sr reg2", 32'(rwr(2)), 0);
    chk("partial stb", 32'(stb_log.size()), 0);
    wr_reg(8'd2, 16'h1234, acks);
    chk("after partial reg2", 32'(rwr(2)), 32'h1234);

    // reset while the target is driving a 0 during a read of reg0 (0xA55A)
    i2c_start();
    wbyte(8'h82, a); wbyte(8'h00, a);
    i2c_start();
    wbyte(8'h83, a);
    rbit(a);
    chk("midrd bit7", 32'(a), 1);
    sda_m = 1'b1; #Q;
    chk("midrd drive0", 32'(sda_oe), 1);
    @(negedge clk) rstn = 1'b0;
    @(negedge clk) rstn = 1'b1;
    chk("midrd rst oe", 32'(sda_oe), 0);
    chk("midrd rst busy", 32'(busy), 0);
    chk("midrd rst rw", 32'(rw_data != '0), 0);
    oe_cycles = 0;
    for (int i = 0; i < 6; i++) rbit(a);
    wbyte(8'h82, a);
    chk("post rst no start ack", 32'(a), 0);
    i2c_stop();
    chk("post rst oe", 32'(oe_cycles), 0);
    i2c_start();
    wbyte(8'h83, a);
    chk("post rst addr ack", 32'(a), 1);
    rbyte(d0, 1'b1); rbyte(d1, 1'b0);
    i2c_stop();
    chk("post rst reg0", 32'({d0, d1}), 0);
    chk("stb onehot", 32'(stb_multi), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
